checksum_checker: RTL and testbench

Receive-side counterpart of the bitchecksum generator. Accepts a framed stream of 32-bit words under a valid/ready handshake and accumulates an 8-bit modulo-256 byte sum. On the last word it compares the sum against the transmitted checksum byte and reports pass/fail. Sits at the link receive path, ahead of any consumer that must drop corrupted frames.

---
 rtl/checksum_checker.sv | 200 ++++++++++++++++++++
 tb/tb_checksum_checker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checksum_checker.sv
`default_nettype none
// ============================================================================
// Module   : checksum_checker
// Purpose  : Receive-side modulo-256 byte-sum checker for framed 32-bit words.
//            Optional failed-frame counter enabled by CHECKSUM_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module checksum_checker #(
    parameter int DATA_W    = 32,
    parameter int CHK_W     = 8,
    parameter int MAX_WORDS = 16,
    parameter int CNT_W     = 8,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 data_valid,
    input  logic                 data_last,
    input  logic [CHK_W-1:0]     chk_in,
    output logic                 data_ready,
    output logic                 chk_done,
    output logic                 chk_ok,
    output logic                 chk_err,
    output logic                 len_err,
    output logic [CNT_W-1:0]     word_cnt
`ifdef CHECKSUM_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_DISCARD = 2'd2,
        ST_CHECK   = 2'd3
    } state_t;

    localparam int              c_bytes   = DATA_W / 8;
    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_WORDS);

    // Unsupported parameter combinations elaborate no extra hardware.
    if ((DATA_W % 8 != 0) || (CHK_W != 8) || (MAX_WORDS < 1) ||
        (CNT_W < $clog2(MAX_WORDS + 1)) || (ERR_CNT_W < 1)) begin : g_param_check
    end

    function automatic logic [CHK_W-1:0] f_word_sum(input logic [DATA_W-1:0] w);
        logic [CHK_W-1:0] s;
        s = '0;
        for (int i = 0; i < c_bytes; i++) begin
            s = s + CHK_W'(w[i*8 +: 8]);
        end
        return s;
    endfunction

    state_t           state_q, state_d;
    logic [CHK_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             len_flag_q, len_flag_d;
    logic [CHK_W-1:0] chk_q, chk_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             len_err_q, len_err_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    logic             w_accept;
    logic [CHK_W-1:0] w_word_sum;
    logic [CHK_W-1:0] w_total;
    logic             w_pass;
    logic             w_frame_ok;

    assign data_ready = !rst && (state_q != ST_CHECK);
    assign w_accept   = data_valid && data_ready;
    assign w_word_sum = f_word_sum(data_in);
    assign w_total    = acc_q + chk_q;
    assign w_pass     = (w_total == '0);
    assign w_frame_ok = !len_flag_q && w_pass;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_flag_d = len_flag_q;
        chk_d      = chk_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        err_d      = err_q;
        len_err_d  = len_err_q;
        word_cnt_d = word_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    acc_d      = w_word_sum;
                    cnt_d      = CNT_W'(1);
                    len_flag_d = 1'b0;
                    if (data_last) begin
                        chk_d   = chk_in;
                        state_d = ST_CHECK;
                    end else if (MAX_WORDS == 1) begin
                        len_flag_d = 1'b1;
                        state_d    = ST_DISCARD;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (w_accept) begin
                    acc_d = acc_q + w_word_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (data_last) begin
                        chk_d   = chk_in;
                        state_d = ST_CHECK;
                    end else if (cnt_d == c_max_cnt) begin
                        len_flag_d = 1'b1;
                        state_d    = ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                // Overlong frame: swallow beats until the end marker.
                if (w_accept && data_last) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                done_d     = 1'b1;
                len_err_d  = len_flag_q;
                ok_d       = w_frame_ok;
                err_d      = !w_frame_ok;
                word_cnt_d = cnt_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_flag_q <= 1'b0;
            chk_q      <= '0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            len_err_q  <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_flag_q <= len_flag_d;
            chk_q      <= chk_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            len_err_q  <= len_err_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign chk_done = done_q;
    assign chk_ok   = ok_q;
    assign chk_err  = err_q;
    assign len_err  = len_err_q;
    assign word_cnt = word_cnt_q;

`ifdef CHECKSUM_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Counts at the same edge that raises chk_done; saturates at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == ST_CHECK) && !w_frame_ok && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    // Failed-frame counter not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_checksum_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_checksum_checker
// Purpose  : Directed and randomized checks of checksum_checker against a
//            frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_checksum_checker;

    localparam int DATA_W    = 32;
    localparam int CHK_W     = 8;
    localparam int MAX_WORDS = 4;
    localparam int CNT_W     = 8;
    localparam int ERR_CNT_W = 2;
    localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] data_in = '0;
    logic              data_valid = 1'b0;
    logic              data_last = 1'b0;
    logic [CHK_W-1:0]  chk_in = '0;
    logic              data_ready;
    logic              chk_done;
    logic              chk_ok;
    logic              chk_err;
    logic              len_err;
    logic [CNT_W-1:0]  word_cnt;
`ifdef CHECKSUM_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_count;
`endif

    checksum_checker #(
        .DATA_W    (DATA_W),
        .CHK_W     (CHK_W),
        .MAX_WORDS (MAX_WORDS),
        .CNT_W     (CNT_W),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_last  (data_last),
        .chk_in     (chk_in),
        .data_ready (data_ready),
        .chk_done   (chk_done),
        .chk_ok     (chk_ok),
        .chk_err    (chk_err),
        .len_err    (len_err),
        .word_cnt   (word_cnt)
`ifdef CHECKSUM_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             ok;
        logic             err;
        logic             len;
        logic [CNT_W-1:0] wc;
    } exp_t;

    exp_t exp_q[$];
    exp_t held;
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   stalls   = 0;
    int   exp_errs = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Frame-level reference: byte sum of the words kept (at most MAX_WORDS).
    function automatic exp_t model(input logic [31:0] w[$], input logic [7:0] chk);
        exp_t e;
        int   n    = w.size();
        int   used = (n > MAX_WORDS) ? MAX_WORDS : n;
        int   s    = 0;
        for (int i = 0; i < used; i++)
            for (int b = 0; b < 4; b++)
                s += int'(w[i][8*b +: 8]);
        e.len = (n > MAX_WORDS);
        e.ok  = !e.len && (((s + int'(chk)) % 256) == 0);
        e.err = !e.ok;
        e.wc  = CNT_W'(used);
        return e;
    endfunction

    function automatic logic [7:0] good_chk(input logic [31:0] w[$]);
        int s = 0;
        foreach (w[i])
            for (int b = 0; b < 4; b++)
                s += int'(w[i][8*b +: 8]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    task automatic drive_beat(input logic [31:0] d, input logic last,
                              input logic [7:0] chk, input int gap);
        int guard;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        data_in    = d;
        data_last  = last;
        chk_in     = chk;
        data_valid = 1'b1;
        guard      = 0;
        @(negedge clk);
        while (!data_ready && guard < 20) begin
            stalls++;
            guard++;
            @(negedge clk);
        end
        if (!data_ready) check("beat_accept_timeout", 32'(data_ready), 32'd1);
        @(posedge clk); #1;
        data_valid = 1'b0;
        data_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] w[$], input logic [7:0] chk, input int gap_max);
        exp_q.push_back(model(w, chk));
        foreach (w[i]) begin
            drive_beat(w[i], (i == w.size() - 1),
                       (i == w.size() - 1) ? chk : 8'($urandom),
                       (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (chk_done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_chk_done", 32'(chk_done), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("chk_ok", 32'(chk_ok), 32'(mon_e.ok));
                    check("chk_err", 32'(chk_err), 32'(mon_e.err));
                    check("len_err", 32'(len_err), 32'(mon_e.len));
                    check("word_cnt", 32'(word_cnt), 32'(mon_e.wc));
`ifdef CHECKSUM_ERR_CNT_EN
                    if (mon_e.err && exp_errs < ERR_MAX) exp_errs++;
                    check("err_count", 32'(err_count), 32'(exp_errs));
`endif
                    held = mon_e;
                end
            end else begin
                check("results_held", 32'({chk_ok, chk_err, len_err, word_cnt}),
                      32'({held.ok, held.err, held.len, held.wc}));
`ifdef CHECKSUM_ERR_CNT_EN
                check("err_count_held", 32'(err_count), 32'(exp_errs));
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w[$];
        logic [7:0]  c;
        int          len;

        held = '{ok: 1'b0, err: 1'b0, len: 1'b0, wc: '0};

        // Reset state
        idle(3);
        check("reset_ready", 32'(data_ready), 32'd0);
        check("reset_outputs", 32'({chk_done, chk_ok, chk_err, len_err, word_cnt}), 32'd0);
`ifdef CHECKSUM_ERR_CNT_EN
        check("reset_err_count", 32'(err_count), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(data_ready), 32'd1);
        @(posedge clk); #1;

        // Single-word frame with exact latency
        w = '{32'h0000_0001};
        send_frame(w, 8'hFF, 0);
        check("lat_check_done_low", 32'(chk_done), 32'd0);
        check("lat_check_ready_low", 32'(data_ready), 32'd0);
        idle(1);
        check("lat_done_high", 32'(chk_done), 32'd1);
        check("single_ok", 32'(chk_ok), 32'd1);
        check("single_word_cnt", 32'(word_cnt), 32'd1);
        idle(1);
        check("done_one_cycle", 32'(chk_done), 32'd0);

        // Two-word frame, correct and incorrect checksum
        w = '{32'h0102_0304, 32'h1000_0000};
        send_frame(w, 8'hE6, 0);
        idle(3);
        check("two_word_ok", 32'(chk_ok), 32'd1);
        send_frame(w, 8'hE7, 0);
        idle(3);
        check("two_word_bad_err", 32'(chk_err), 32'd1);

        // Overlong frame and maximum-length legal frame
        w = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        send_frame(w, good_chk(w), 0);
        idle(3);
        check("overlong_len_err", 32'(len_err), 32'd1);
        check("overlong_word_cnt", 32'(word_cnt), 32'd4);
        w = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_0001};
        send_frame(w, good_chk(w), 0);
        idle(3);
        check("max_len_ok", 32'(chk_ok), 32'd1);

        // Back-to-back frames with valid held: one stall per CHECK cycle
        stalls = 0;
        w = '{$urandom, $urandom};
        send_frame(w, good_chk(w), 0);
        w = '{$urandom, $urandom, $urandom};
        send_frame(w, good_chk(w) ^ 8'h01, 0);
        w = '{$urandom};
        send_frame(w, good_chk(w), 0);
        check("b2b_stalls", 32'(stalls), 32'd2);
        idle(3);

        // Reset in the middle of a frame
        drive_beat(32'hAAAA_5555, 1'b0, 8'h00, 0);
        drive_beat(32'h1111_2222, 1'b0, 8'h00, 0);
        rst      = 1'b1;
        held     = '{ok: 1'b0, err: 1'b0, len: 1'b0, wc: '0};
        exp_errs = 0;
        idle(1);
        check("midreset_ready", 32'(data_ready), 32'd0);
        check("midreset_outputs", 32'({chk_done, chk_ok, chk_err, len_err, word_cnt}), 32'd0);
        rst = 1'b0;
        idle(2);
        w = '{32'hFFFF_FFFF};
        send_frame(w, 8'h04, 0);
        idle(3);
        check("after_reset_ok", 32'(chk_ok), 32'd1);

        // Three failing frames, one more passing frame
        for (int i = 0; i < 3; i++) begin
            w = '{$urandom};
            send_frame(w, good_chk(w) + 8'd1 + 8'(i), 0);
        end
        w = '{32'h0000_0000, 32'h0000_0000};
        send_frame(w, 8'h00, 0);
        idle(3);
        check("zero_sum_ok", 32'(chk_ok), 32'd1);
`ifdef CHECKSUM_ERR_CNT_EN
        check("err_count_three", 32'(err_count), 32'd3);
`endif

        // Randomized frames with gaps
        for (int f = 0; f < 40; f++) begin
            w   = {};
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) w.push_back($urandom);
            c = ($urandom_range(0, 1) == 1) ? good_chk(w) : 8'($urandom);
            send_frame(w, c, 2);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(5);
        check("all_results_seen", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
